noc_link_vc_mux: RTL and testbench
==================================

# noc_link_vc_mux

Credit-based NoC link multiplexer that carries NUM_CH independent flit channels over one physical mesh link between neighbouring routers. It buffers each channel in its own FIFO and time-interleaves channels onto the shared link with a round-robin grant that rotates every INTERLEAVING_GRAIN cycles. It is instantiated once per link direction in the generated mesh, between a router's output port and its neighbour's input port, replacing the direct point-to-point wiring. Border ports remain grounded.

## Interface
- FLIT_WIDTH, 32: flit width in bits.
- NUM_CH, 2: number of channels, ≥1.
- DEPTH, 4: per-channel FIFO depth, power of 2, ≥2.
- INTERLEAVING_GRAIN, 10: maximum consecutive cycles one channel holds the grant, ≥1.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_i  in  NUM_CH  per-channel upstream flit valid.
- data_i  in  NUM_CH*FLIT_WIDTH  per-channel flits; channel c occupies bits [c*FLIT_WIDTH +: FLIT_WIDTH].
- credit_o  out  NUM_CH  per-channel "FIFO can accept".
- tx_o  out  1  downstream flit valid.
- ch_o  out  CH_W  channel of the presented flit; CH_W = max(1, clog2(NUM_CH)).
- data_o  out  FLIT_WIDTH  presented flit.
- credit_i  in  NUM_CH  per-channel downstream "can accept".

## Operation
- Push: channel c accepts a flit on a rising edge when rx_i[c] && credit_o[c].
- credit_o[c] = (count[c] < DEPTH) && reset deasserted. A same-cycle pop does not free a slot for a push.
- Output: g is the granted channel.
  - tx_o = (count[g] > 0).
  - data_o = FIFO[g] head, or 0 when tx_o = 0.
  - ch_o = g.
- Pop: a flit is consumed on the edge where tx_o && credit_i[g].
- Per-channel order is preserved. No flit is dropped or duplicated.
- Arbiter state: g and grain_cnt.
- At every edge, let ne[k] = count_next[k] > 0, where count_next includes same-cycle push and pop.
- Rotate when grain_cnt == INTERLEAVING_GRAIN-1 or !ne[g].
  - Rotate means: g ← first k in g+1 … g+NUM_CH-1 (mod NUM_CH) with ne[k]; grain_cnt ← 0.
  - If no such k exists, g is unchanged and grain_cnt ← 0.
- Otherwise grain_cnt ← grain_cnt+1.
- grain_cnt counts held cycles, not transfers, so a channel blocked by credit_i releases the grant after the grain and cannot starve others.
- NUM_CH = 1: g is constant 0; the block degenerates to a single FIFO.

## Timing
- Reset values, applied asynchronously:
  - all FIFOs empty;
  - g = 0, grain_cnt = 0;
  - tx_o = 0, ch_o = 0, data_o = 0;
  - credit_o = 0 while reset is low, all ones from the first cycle after release.
- Latency: a flit accepted at edge t is presented at tx_o after edge t (1 cycle), provided its channel is granted by or at edge t. The arbiter sees the same-cycle push through ne.
- Throughput: 1 flit/cycle on the link while the granted channel is non-empty and credited.
- Full: the DEPTH-th push drops credit_o[c] after the same edge. It rises again the cycle after a pop.
- Empty granted channel with others pending: grant moves at the same edge, with no idle cycle.
- Reset mid-operation: all buffered flits are discarded, no partial state is kept, and outputs go to reset values immediately.

## Structure
- noc_pkg (shared package):
  - e_port enum: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4;
  - parameterised flit typedef;
  - ch_width function.
- Sub-module noc_credit_fifo: one per channel, generated. It provides push/pop, count, head, and full/empty.
- The arbiter and output mux live in noc_link_vc_mux.

## Test plan
- Reset: hold reset low 3 cycles with rx_i = 11 → credit_o = 00 and tx_o = 0 throughout. One cycle after release, credit_o = 11.
- Single flit: push 0xCAFE0001 on channel 1 with credit_i = 11 → next cycle tx_o = 1, ch_o = 1, data_o = 0xCAFE0001 for exactly one cycle, then tx_o = 0.
- Backpressure fill: credit_i = 00, offer 5 flits 0x1–0x5 on channel 0 → credit_o[0] = 0 after the 4th; 0x5 is held upstream. Then set credit_i = 01 → output 0x1, 0x2, 0x3, 0x4, 0x5 in order.
- Interleave: both channels continuously offering 16 flits, credit_i = 11 → ch_o sequence is 10×0, 10×1, 6×0, 6×1, with no gaps.
- Starvation guard: channel 0 loaded with credit_i[0] = 0, channel 1 loaded with credit_i[1] = 1 → no transfers for 10 cycles, then channel 1 streams. No channel-0 flit is lost once credit_i[0] returns.
- Mid-stream reset: assert reset during the interleave test → tx_o = 0 immediately and all counts 0. After release, the first output is the first flit pushed after reset.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port enumeration, flit type and width helpers.
package noc_pkg;

    typedef enum logic [2:0] {
        EAST  = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        SOUTH = 3'd3,
        LOCAL = 3'd4
    } e_port;

    localparam int FLIT_WIDTH_DFLT = 32;

    typedef logic [FLIT_WIDTH_DFLT-1:0] flit_t;

    // Width of an index over n items, never less than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_link_vc_mux_if.sv
// Link bundle: per-channel upstream flits/credits and the shared downstream link.
interface noc_link_vc_mux_if
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int NUM_CH     = 2
);
    localparam int CH_W = ch_width(NUM_CH);

    logic [NUM_CH-1:0]            rx_i;
    logic [NUM_CH*FLIT_WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]            credit_o;
    logic                         tx_o;
    logic [CH_W-1:0]              ch_o;
    logic [FLIT_WIDTH-1:0]        data_o;
    logic [NUM_CH-1:0]            credit_i;

    // Multiplexer side.
    modport slave (
        input  rx_i, data_i, credit_i,
        output credit_o, tx_o, ch_o, data_o
    );

    // Environment side: upstream router and downstream neighbour.
    modport master (
        output rx_i, data_i, credit_i,
        input  credit_o, tx_o, ch_o, data_o
    );

endinterface

// File: rtl/noc_credit_fifo.sv
// Per-channel flit FIFO with occupancy count and a combinational head view.
module noc_credit_fifo
    import noc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = ch_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    // The head must be visible in the same cycle the arbiter grants, so the
    // storage is read asynchronously; the FIFO is only a handful of entries.
    assign head    = mem[rd_ptr_reg];

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/noc_link_vc_mux.sv
// Multiplexes NUM_CH credit-based flit channels onto one link with a
// time-sliced round-robin grant.
module noc_link_vc_mux
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH         = 32,
    parameter int NUM_CH             = 2,
    parameter int DEPTH              = 4,
    parameter int INTERLEAVING_GRAIN = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    noc_link_vc_mux_if.slave  link
);
    localparam int CH_W = ch_width(NUM_CH);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int GW   = ch_width(INTERLEAVING_GRAIN);

    logic [CW-1:0]         count [NUM_CH];
    logic [FLIT_WIDTH-1:0] head  [NUM_CH];
    logic [NUM_CH-1:0]     full;
    logic [NUM_CH-1:0]     empty;
    logic [NUM_CH-1:0]     push;
    logic [NUM_CH-1:0]     pop;
    logic [NUM_CH-1:0]     ne;
    logic [NUM_CH-1:0]     credit;
    logic                  tx;

    logic [CH_W-1:0]       g_reg;
    logic [CH_W-1:0]       g_next;
    logic [GW-1:0]         grain_reg;
    logic [GW-1:0]         grain_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // Credit reflects pre-edge occupancy only; a same-cycle pop does not
            // open a slot for a push.
            assign credit[gi] = !full[gi] && rst_n;
            assign push[gi]   = link.rx_i[gi] && credit[gi];
            assign pop[gi]    = tx && link.credit_i[gi] && (g_reg == CH_W'(gi));
            // Channel still holds a flit after this edge's push and pop.
            assign ne[gi]     = push[gi] || (count[gi] > CW'(pop[gi]));

            noc_credit_fifo #(
                .WIDTH (FLIT_WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push[gi]),
                .push_data (link.data_i[gi*FLIT_WIDTH +: FLIT_WIDTH]),
                .pop       (pop[gi]),
                .count     (count[gi]),
                .head      (head[gi]),
                .full      (full[gi]),
                .empty     (empty[gi])
            );
        end
    endgenerate

    assign tx            = !empty[g_reg];
    assign link.credit_o = credit;
    assign link.tx_o     = tx;
    assign link.ch_o     = g_reg;
    assign link.data_o   = tx ? head[g_reg] : '0;

    // Grant rotation: leave the channel when its slice expires or it drains,
    // moving to the next channel in round-robin order that will hold data.
    always_comb begin
        logic            found;
        logic [CH_W-1:0] cand;
        g_next     = g_reg;
        grain_next = grain_reg + 1'b1;
        found      = 1'b0;
        cand       = '0;
        if ((grain_reg == GW'(INTERLEAVING_GRAIN - 1)) || !ne[g_reg]) begin
            grain_next = '0;
            for (int i = 1; i < NUM_CH; i++) begin
                if (int'(g_reg) + i >= NUM_CH) begin
                    cand = CH_W'(int'(g_reg) + i - NUM_CH);
                end else begin
                    cand = CH_W'(int'(g_reg) + i);
                end
                if (!found && ne[cand]) begin
                    g_next = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_reg     <= '0;
            grain_reg <= '0;
        end else begin
            g_reg     <= g_next;
            grain_reg <= grain_next;
        end
    end

endmodule

// File: tb/tb_noc_link_vc_mux.sv
// Scoreboard bench for noc_link_vc_mux: queue-based reference of the link.
module tb_noc_link_vc_mux;
    import noc_pkg::*;

    localparam int FW  = 32;
    localparam int NCH = 2;
    localparam int DEP = 4;
    localparam int GR  = 10;
    localparam int DW  = NCH * FW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_link_vc_mux_if #(.FLIT_WIDTH(FW), .NUM_CH(NCH)) link_if();

    noc_link_vc_mux #(
        .FLIT_WIDTH         (FW),
        .NUM_CH             (NCH),
        .DEPTH              (DEP),
        .INTERLEAVING_GRAIN (GR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (link_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    flit_t mq    [NCH][$];   // expected flits held in the link, per channel
    flit_t src_q [NCH][$];   // flits still waiting upstream
    int    mg = 0;           // reference grant
    int    mgrain = 0;       // reference held-cycle count
    bit    m_push [NCH];
    bit    m_pop;
    bit    acc    [NCH];
    int    sent   [NCH];
    int    dut_xfer [NCH];
    bit    dense = 1'b1;
    bit    cred_rand = 1'b0;
    logic [NCH-1:0] cred_fix = '1;
    bit    arm_first = 1'b0;
    flit_t first_data = '0;

    function automatic logic bit_at(input logic [NCH-1:0] v, input int i);
        logic [NCH-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic flit_t flit_at(input logic [DW-1:0] v, input int i);
        return flit_t'(v >> (i * FW));
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    function automatic void clear_counts();
        for (int c = 0; c < NCH; c++) begin
            sent[c]     = 0;
            dut_xfer[c] = 0;
        end
    endfunction

    // Reference model: per-channel queues and the slice/round-robin grant rules.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int c = 0; c < NCH; c++) mq[c].delete();
                mg     = 0;
                mgrain = 0;
            end else begin
                for (int c = 0; c < NCH; c++)
                    m_push[c] = bit_at(link_if.rx_i, c) && (mq[c].size() < DEP);
                m_pop = (mq[mg].size() > 0) && bit_at(link_if.credit_i, mg);
                if (m_pop) void'(mq[mg].pop_front());
                for (int c = 0; c < NCH; c++)
                    if (m_push[c]) mq[c].push_back(flit_at(link_if.data_i, c));
                if (mgrain == GR - 1 || mq[mg].size() == 0) begin
                    mgrain = 0;
                    for (int i = 1; i < NCH; i++) begin
                        int k;
                        k = (mg + i) % NCH;
                        if (mq[k].size() > 0) begin
                            mg = k;
                            break;
                        end
                    end
                end else begin
                    mgrain++;
                end
            end
        end
    end

    // Monitor: compare the presented link state against the reference each cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                acc[c] = bit_at(link_if.rx_i, c) && bit_at(link_if.credit_o, c);
                check("credit_o", 64'(bit_at(link_if.credit_o, c)),
                      64'(rst_n && (mq[c].size() < DEP)));
            end
            check("tx_o", 64'(link_if.tx_o), 64'(mq[mg].size() > 0));
            check("ch_o", 64'(link_if.ch_o), 64'(mg));
            if (mq[mg].size() > 0) check("data_o", 64'(link_if.data_o), 64'(mq[mg][0]));
            else                   check("data_o_idle", 64'(link_if.data_o), 64'd0);
            if (link_if.tx_o && link_if.credit_i[link_if.ch_o]) begin
                dut_xfer[link_if.ch_o]++;
                $display("xfer t=%0t ch=%0d data=%08h", $time, link_if.ch_o, link_if.data_o);
                if (arm_first) begin
                    first_data = link_if.data_o;
                    arm_first  = 1'b0;
                end
            end
        end
    end

    // One cycle of upstream/downstream stimulus, driven just after the edge.
    task automatic step();
        logic [NCH-1:0] rx_v;
        logic [DW-1:0]  d_v;
        @(posedge clk);
        #2;
        rx_v = '0;
        d_v  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (acc[c] && src_q[c].size() > 0) begin
                void'(src_q[c].pop_front());
                sent[c]++;
            end
            if (src_q[c].size() > 0 && (dense || $urandom_range(0, 3) != 0)) begin
                rx_v = rx_v | (NCH'(1) << c);
                d_v  = d_v | (DW'(src_q[c][0]) << (c * FW));
            end else begin
                d_v  = d_v | (DW'($urandom) << (c * FW));
            end
        end
        link_if.rx_i     = rx_v;
        link_if.data_i   = d_v;
        link_if.credit_i = cred_rand ? NCH'($urandom) : cred_fix;
    endtask

    initial begin
        int guard;
        link_if.rx_i     = '1;
        link_if.data_i   = '0;
        link_if.credit_i = '1;
        clear_counts();

        // Reset held three cycles with valid asserted.
        repeat (3) @(posedge clk);
        #2;
        link_if.rx_i = '0;
        rst_n = 1'b1;
        repeat (2) step();

        // Single flit on channel 1.
        src_q[1].push_back(32'hCAFE0001);
        repeat (5) step();
        check("single_xfer", 64'(dut_xfer[1]), 64'd1);

        // Backpressure fill on channel 0.
        clear_counts();
        cred_fix = 2'b00;
        for (int i = 1; i <= 5; i++) src_q[0].push_back(flit_t'(i));
        repeat (8) step();
        check("bp_credit0", 64'(link_if.credit_o[0]), 64'd0);
        check("bp_held_cnt", 64'(src_q[0].size()), 64'd1);
        check("bp_held_val", 64'(src_q[0][0]), 64'd5);
        cred_fix = 2'b01;
        repeat (12) step();
        check("bp_drained", 64'(dut_xfer[0]), 64'd5);

        // Interleave: both channels streaming.
        clear_counts();
        cred_fix = 2'b11;
        for (int i = 0; i < 16; i++) begin
            src_q[0].push_back(32'hA0000000 + i);
            src_q[1].push_back(32'hB0000000 + i);
        end
        repeat (60) step();
        check("il_xfer0", 64'(dut_xfer[0]), 64'd16);
        check("il_xfer1", 64'(dut_xfer[1]), 64'd16);

        // Starvation guard: channel 0 blocked downstream.
        clear_counts();
        cred_fix = 2'b10;
        for (int i = 0; i < 4; i++) src_q[0].push_back(32'h50000000 + i);
        repeat (3) step();
        for (int i = 0; i < 4; i++) src_q[1].push_back(32'h51000000 + i);
        repeat (30) step();
        check("sg_xfer1", 64'(dut_xfer[1]), 64'd4);
        check("sg_xfer0_blocked", 64'(dut_xfer[0]), 64'd0);
        cred_fix = 2'b11;
        repeat (15) step();
        check("sg_xfer0_released", 64'(dut_xfer[0]), 64'd4);

        // Mid-stream reset.
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            src_q[0].push_back(32'hC0000000 + i);
            src_q[1].push_back(32'hC1000000 + i);
        end
        repeat (12) step();
        rst_n = 1'b0;
        #1;
        check("rst_tx_o", 64'(link_if.tx_o), 64'd0);
        check("rst_data_o", 64'(link_if.data_o), 64'd0);
        check("rst_credit_o", 64'(link_if.credit_o), 64'd0);
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        link_if.rx_i = '0;
        clear_counts();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        arm_first = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_q[0].push_back(32'hD00D0000 + i);
            src_q[1].push_back(32'hE00E0000 + i);
        end
        repeat (20) step();
        check("rst_first_out", 64'(first_data), 64'hD00D0000);
        check("rst_xfer0", 64'(dut_xfer[0]), 64'd4);
        check("rst_xfer1", 64'(dut_xfer[1]), 64'd4);

        // Randomized traffic with random downstream credit.
        clear_counts();
        cred_rand = 1'b1;
        dense     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            src_q[0].push_back(flit_t'($urandom));
            src_q[1].push_back(flit_t'($urandom));
        end
        repeat (150) step();
        cred_rand = 1'b0;
        cred_fix  = 2'b11;
        dense     = 1'b1;
        guard = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0 ||
                mq[0].size() > 0 || mq[1].size() > 0) && guard < 300) begin
            step();
            guard++;
        end
        check("drain_in_time", 64'(guard < 300), 64'd1);
        repeat (3) step();
        for (int c = 0; c < NCH; c++) begin
            check("rand_sent", 64'(sent[c]), 64'd40);
            check("rand_delivered", 64'(dut_xfer[c]), 64'(sent[c]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
